serial_to_parallel: RTL

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

---
 rtl/serial_to_parallel.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_to_parallel.sv
// Strobed serial-to-parallel receiver: start bit 0, WIDTH data bits LSB first, stop bit 1.
// Define PARITY_CHECK_EN to expect an even-parity bit between the data and the stop bit.
module serial_to_parallel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_STOP = 2'd3;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [1:0] S_AFTER_DATA = S_STOP;
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             frame_err_q, frame_err_d;
`ifdef PARITY_CHECK_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;
    logic             perr;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        q_d         = q_q;
        q_valid_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef PARITY_CHECK_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
        // even parity: data bits plus parity bit must XOR to zero
        perr         = ^{shift_q, par_q};
`endif
        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!sin) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    shift_d[cnt_q] = sin;
                    if (cnt_q == LAST) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                S_PARITY: begin
                    par_d   = sin;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    frame_err_d  = !sin;
                    parity_err_d = perr;
                    if (sin && !perr) begin
                        q_d       = shift_q;
                        q_valid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
`else
                S_STOP: begin
                    frame_err_d = !sin;
                    if (sin) begin
                        q_d       = shift_q;
                        q_valid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            frame_err_q <= frame_err_d;
`ifdef PARITY_CHECK_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);
`ifdef PARITY_CHECK_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
